alu_mdu_pipe: RTL and testbench

//  Parametrised execute-stage unit for the in-order MIPS pipeline: the full ALU op set plus MULT/MULTU/DIV/DIVU,

---
 rtl/mips_pkg.sv | 33 +++
 rtl/div_iter.sv | 66 ++++++
 rtl/alu_mdu_pipe.sv | 182 ++++++++++++++++++
 tb/tb_alu_mdu_pipe.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/mips_pkg.sv
// Shared MIPS execute-stage types: ALU/MDU operation codes and the MDU sequencing states.
package mips_pkg;

  typedef enum logic [4:0] {
    ALU_AND   = 5'd0,
    ALU_OR    = 5'd1,
    ALU_XOR   = 5'd2,
    ALU_NOR   = 5'd3,
    ALU_ADD   = 5'd4,
    ALU_ADDU  = 5'd5,
    ALU_SUB   = 5'd6,
    ALU_SUBU  = 5'd7,
    ALU_SLT   = 5'd8,
    ALU_SLTU  = 5'd9,
    ALU_SLL   = 5'd10,
    ALU_SRL   = 5'd11,
    ALU_SRA   = 5'd12,
    ALU_LUI   = 5'd13,
    ALU_PASSA = 5'd14,
    ALU_PASSB = 5'd15,
    MDU_MULT  = 5'd16,
    MDU_MULTU = 5'd17,
    MDU_DIV   = 5'd18,
    MDU_DIVU  = 5'd19
  } aluop_t;

  typedef enum logic [1:0] {IDLE, MUL, DIV, DONE} mdu_state_t;

  function automatic logic is_mdu(aluop_t f);
    return (f == MDU_MULT) || (f == MDU_MULTU) || (f == MDU_DIV) || (f == MDU_DIVU);
  endfunction

endpackage

// File: rtl/div_iter.sv
// Radix-2 restoring divider on operand magnitudes, one quotient bit per cycle;
// q/r are sign-corrected combinationally while done is high.
module div_iter #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             sgn,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] r
);

  localparam int CW = $clog2(WIDTH + 1);

  logic [WIDTH-1:0] rem_reg, quo_reg, dvs_reg, dvd_reg;
  logic [CW-1:0]    cnt_reg;
  logic             busy_reg, done_reg, q_neg_reg, r_neg_reg, b_zero_reg;
  logic             a_neg, b_neg;
  logic [WIDTH:0]   shifted, diff;

  assign a_neg   = sgn & a[WIDTH-1];
  assign b_neg   = sgn & b[WIDTH-1];
  assign shifted = {rem_reg, quo_reg[WIDTH-1]};
  assign diff    = shifted - {1'b0, dvs_reg};

  always_ff @(posedge clk) begin
    if (reset) begin
      busy_reg <= 1'b0;
      done_reg <= 1'b0;
    end else begin
      done_reg <= 1'b0;
      if (start) begin
        busy_reg   <= 1'b1;
        cnt_reg    <= CW'(WIDTH);
        rem_reg    <= '0;
        quo_reg    <= a_neg ? -a : a;
        dvs_reg    <= b_neg ? -b : b;
        dvd_reg    <= a;
        q_neg_reg  <= a_neg ^ b_neg;
        r_neg_reg  <= a_neg;
        b_zero_reg <= (b == '0);
      end else if (busy_reg) begin
        // A borrow out of the trial subtraction means this quotient bit is 0: keep the old remainder.
        rem_reg <= diff[WIDTH] ? shifted[WIDTH-1:0] : diff[WIDTH-1:0];
        quo_reg <= {quo_reg[WIDTH-2:0], ~diff[WIDTH]};
        cnt_reg <= cnt_reg - CW'(1);
        if (cnt_reg == CW'(1)) begin
          busy_reg <= 1'b0;
          done_reg <= 1'b1;
        end
      end
    end
  end

  assign busy = busy_reg;
  assign done = done_reg;
  // Divide-by-zero bypasses sign correction so the quotient stays all ones and hi echoes the dividend.
  assign q = b_zero_reg ? '1 : (q_neg_reg ? -quo_reg : quo_reg);
  assign r = b_zero_reg ? dvd_reg : (r_neg_reg ? -rem_reg : rem_reg);

endmodule

// File: rtl/alu_mdu_pipe.sv
// Execute-stage ALU plus MULT/DIV unit behind a valid/ready handshake; ALU ops take one
// cycle, multiplies run through a fixed-latency pipe, divides through div_iter.
module alu_mdu_pipe
  import mips_pkg::*;
#(
  parameter int WIDTH   = 32,
  parameter int MUL_LAT = 3,
  parameter int EN_MDU  = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  aluop_t           func,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] c,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo,
  output logic             hilo_we,
  output logic             exception_of
);

  localparam int SHW  = $clog2(WIDTH);
  localparam int HW   = WIDTH / 2;
  localparam int NSTG = MUL_LAT - 1;

  mdu_state_t       state_reg;
  logic             out_valid_reg, hilo_we_reg, exc_reg;
  logic [WIDTH-1:0] c_reg, hi_reg, lo_reg;

  logic             accept, mdu_op, acc_mul, acc_div;
  logic [SHW-1:0]   shamt;
  logic [WIDTH:0]   add_x, sub_x;
  logic [WIDTH-1:0] alu_c;
  logic             alu_ov;
  logic [2*WIDTH-1:0] mul_a, mul_b, prod, mul_res;
  logic             mul_fire;
  logic             div_busy, div_done;
  logic [WIDTH-1:0] div_q, div_r;

  assign in_ready = (state_reg == IDLE) & ~div_busy & (~out_valid_reg | out_ready) & ~flush;
  assign accept   = in_valid & in_ready;
  assign mdu_op   = (EN_MDU != 0) && is_mdu(func);
  assign acc_mul  = accept & mdu_op & ((func == MDU_MULT) | (func == MDU_MULTU));
  assign acc_div  = accept & mdu_op & ((func == MDU_DIV) | (func == MDU_DIVU));

  assign shamt = a[SHW-1:0];
  assign add_x = {a[WIDTH-1], a} + {b[WIDTH-1], b};
  assign sub_x = {a[WIDTH-1], a} - {b[WIDTH-1], b};

  always_comb begin
    alu_c  = '0;
    alu_ov = 1'b0;
    case (func)
      ALU_AND:   alu_c = a & b;
      ALU_OR:    alu_c = a | b;
      ALU_XOR:   alu_c = a ^ b;
      ALU_NOR:   alu_c = ~(a | b);
      ALU_ADD: begin
        alu_c  = add_x[WIDTH-1:0];
        alu_ov = add_x[WIDTH] ^ add_x[WIDTH-1];
      end
      ALU_ADDU:  alu_c = a + b;
      ALU_SUB: begin
        alu_c  = sub_x[WIDTH-1:0];
        alu_ov = sub_x[WIDTH] ^ sub_x[WIDTH-1];
      end
      ALU_SUBU:  alu_c = a - b;
      ALU_SLT:   alu_c = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
      ALU_SLTU:  alu_c = {{(WIDTH-1){1'b0}}, (a < b)};
      ALU_SLL:   alu_c = b << shamt;
      ALU_SRL:   alu_c = b >> shamt;
      ALU_SRA:   alu_c = $signed(b) >>> shamt;
      ALU_LUI:   alu_c = {b[HW-1:0], {HW{1'b0}}};
      ALU_PASSA: alu_c = a;
      ALU_PASSB: alu_c = b;
      default:   alu_c = '0;
    endcase
  end

  // Extend both operands to 2*WIDTH so one unsigned multiplier serves MULT and MULTU.
  assign mul_a = (func == MDU_MULT) ? {{WIDTH{a[WIDTH-1]}}, a} : {{WIDTH{1'b0}}, a};
  assign mul_b = (func == MDU_MULT) ? {{WIDTH{b[WIDTH-1]}}, b} : {{WIDTH{1'b0}}, b};
  assign prod  = mul_a * mul_b;

  generate
    if (NSTG == 0) begin : g_mul_direct
      assign mul_fire = acc_mul;
      assign mul_res  = prod;
    end else begin : g_mul_pipe
      logic [2*WIDTH-1:0] stg_reg [NSTG];
      logic               vld_reg [NSTG];
      for (genvar gi = 0; gi < NSTG; gi++) begin : g_stg
        if (gi == 0) begin : g_first
          always_ff @(posedge clk) begin
            vld_reg[gi] <= (reset | flush) ? 1'b0 : acc_mul;
            stg_reg[gi] <= prod;
          end
        end else begin : g_next
          always_ff @(posedge clk) begin
            vld_reg[gi] <= (reset | flush) ? 1'b0 : vld_reg[gi-1];
            stg_reg[gi] <= stg_reg[gi-1];
          end
        end
      end
      assign mul_fire = vld_reg[NSTG-1];
      assign mul_res  = stg_reg[NSTG-1];
    end
  endgenerate

  div_iter #(.WIDTH(WIDTH)) u_div (
    .clk   (clk),
    .reset (reset | flush),
    .start (acc_div),
    .sgn   (func == MDU_DIV),
    .a     (a),
    .b     (b),
    .busy  (div_busy),
    .done  (div_done),
    .q     (div_q),
    .r     (div_r)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
      c_reg         <= '0;
      hi_reg        <= '0;
      lo_reg        <= '0;
      hilo_we_reg   <= 1'b0;
      exc_reg       <= 1'b0;
    end else if (flush) begin
      state_reg     <= IDLE;
      out_valid_reg <= 1'b0;
    end else begin
      if (out_valid_reg && out_ready) begin
        out_valid_reg <= 1'b0;
        if (state_reg == DONE) state_reg <= IDLE;
      end
      if (accept) begin
        if (acc_mul) begin
          state_reg <= MUL;
        end else if (acc_div) begin
          state_reg <= DIV;
        end else begin
          out_valid_reg <= 1'b1;
          c_reg         <= alu_c;
          hi_reg        <= '0;
          lo_reg        <= '0;
          hilo_we_reg   <= 1'b0;
          exc_reg       <= alu_ov;
        end
      end
      // Later assignments win: with a single-cycle multiplier the accept and the result share an edge.
      if (mul_fire || div_done) begin
        state_reg     <= DONE;
        out_valid_reg <= 1'b1;
        c_reg         <= '0;
        hilo_we_reg   <= 1'b1;
        exc_reg       <= 1'b0;
        if (mul_fire) {hi_reg, lo_reg} <= mul_res;
        else begin
          hi_reg <= div_r;
          lo_reg <= div_q;
        end
      end
    end
  end

  assign out_valid    = out_valid_reg;
  assign c            = c_reg;
  assign hi           = hi_reg;
  assign lo           = lo_reg;
  assign hilo_we      = hilo_we_reg;
  assign exception_of = exc_reg;

endmodule

// File: tb/tb_alu_mdu_pipe.sv
// Scoreboard bench for alu_mdu_pipe: expected results are queued at accept and compared,
// with their arrival cycle, whenever the unit presents a result.
module tb_alu_mdu_pipe;
  import mips_pkg::*;

  typedef struct {
    logic [31:0] c;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        we;
    logic        ov;
    int          exp_cyc;
    int          id;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset, flush, in_valid, in_ready, out_valid, out_ready;
  logic [31:0] a, b, c, hi, lo;
  logic        hilo_we, exception_of;
  aluop_t      func;

  int   cyc = 0;
  int   n_pass = 0;
  int   n_checks = 0;
  int   n_ids = 0;
  exp_t scb[$];
  bit   seen = 1'b0;

  alu_mdu_pipe #(.WIDTH(32), .MUL_LAT(3), .EN_MDU(1)) dut (
    .clk          (clk),
    .reset        (reset),
    .flush        (flush),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .a            (a),
    .b            (b),
    .func         (func),
    .out_valid    (out_valid),
    .out_ready    (out_ready),
    .c            (c),
    .hi           (hi),
    .lo           (lo),
    .hilo_we      (hilo_we),
    .exception_of (exception_of)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, cyc);
  endtask

  function automatic exp_t model(input aluop_t f, input logic [31:0] x, input logic [31:0] y,
                                 output int lat);
    exp_t        e;
    longint      sx, sy, s;
    logic [63:0] u;
    e = '{default: 0};
    sx = $signed(x);
    sy = $signed(y);
    lat = 1;
    case (f)
      ALU_AND:   e.c = x & y;
      ALU_OR:    e.c = x | y;
      ALU_XOR:   e.c = x ^ y;
      ALU_NOR:   e.c = ~(x | y);
      ALU_ADD:   begin s = sx + sy; e.c = s[31:0]; e.ov = (s != longint'($signed(s[31:0]))); end
      ALU_ADDU:  e.c = x + y;
      ALU_SUB:   begin s = sx - sy; e.c = s[31:0]; e.ov = (s != longint'($signed(s[31:0]))); end
      ALU_SUBU:  e.c = x - y;
      ALU_SLT:   e.c = (sx < sy) ? 32'd1 : 32'd0;
      ALU_SLTU:  e.c = (x < y) ? 32'd1 : 32'd0;
      ALU_SLL:   e.c = y << x[4:0];
      ALU_SRL:   e.c = y >> x[4:0];
      ALU_SRA:   e.c = 32'($signed(y) >>> x[4:0]);
      ALU_LUI:   e.c = {y[15:0], 16'h0000};
      ALU_PASSA: e.c = x;
      ALU_PASSB: e.c = y;
      MDU_MULT:  begin s = sx * sy; {e.hi, e.lo} = s; e.we = 1'b1; lat = 3; end
      MDU_MULTU: begin u = {32'd0, x} * {32'd0, y}; {e.hi, e.lo} = u; e.we = 1'b1; lat = 3; end
      MDU_DIV, MDU_DIVU: begin
        e.we = 1'b1;
        lat = 34;
        if (y == 32'd0) begin
          e.lo = 32'hFFFF_FFFF;
          e.hi = x;
        end else if (f == MDU_DIV) begin
          s = sx / sy; e.lo = s[31:0];
          s = sx % sy; e.hi = s[31:0];
        end else begin
          e.lo = x / y;
          e.hi = x % y;
        end
      end
      default: ;
    endcase
    return e;
  endfunction

  // Present one op at the current negedge, wait (bounded) for in_ready, queue its expectation.
  task automatic issue(input aluop_t f, input logic [31:0] x, input logic [31:0] y, input bit push);
    int   n = 0;
    int   lat;
    exp_t e;
    func = f; a = x; b = y; in_valid = 1'b1;
    #1;
    while (!in_ready && n < 200) begin
      @(negedge clk); #1; n++;
    end
    if (!in_ready) begin
      check_val("accept_timeout", in_ready, 1);
    end else begin
      e = model(f, x, y, lat);
      e.exp_cyc = cyc + lat;
      e.id = n_ids++;
      if (push) scb.push_back(e);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic wait_drain();
    int n = 0;
    while (scb.size() != 0 && n < 300) begin
      @(negedge clk); n++;
    end
    check_val("drain", scb.size(), 0);
  endtask

  always begin
    exp_t e;
    @(negedge clk); #3;
    if (out_valid) begin
      if (scb.size() == 0) begin
        check_val("spurious_out", out_valid, 0);
      end else begin
        e = scb[0];
        if (!seen) begin
          check_val("latency", cyc, e.exp_cyc);
          seen = 1'b1;
        end
        check_val("c", c, e.c);
        check_val("hi", hi, e.hi);
        check_val("lo", lo, e.lo);
        check_val("hilo_we", hilo_we, e.we);
        check_val("exception_of", exception_of, e.ov);
        if (out_ready) begin
          $display("txn %0d: c=%h hi=%h lo=%h hilo_we=%0b of=%0b at cycle %0d",
                   e.id, c, hi, lo, hilo_we, exception_of, cyc);
          void'(scb.pop_front());
          seen = 1'b0;
        end else begin
          check_val("stall_in_ready", in_ready, 0);
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    aluop_t      alu_ops[12];
    logic [31:0] alu_a[12];
    logic [31:0] alu_b[12];
    logic [4:0]  unk;
    reset = 1'b1; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    func = ALU_AND; a = '0; b = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk); #1;
    check_val("rst_out_valid", out_valid, 0);
    check_val("rst_c", c, 0);
    check_val("rst_hi", hi, 0);
    check_val("rst_lo", lo, 0);
    check_val("rst_hilo_we", hilo_we, 0);
    check_val("rst_exc", exception_of, 0);
    check_val("rst_in_ready", in_ready, 1);
    @(negedge clk);

    // Overflow boundary and back-to-back single-cycle ops.
    issue(ALU_ADD,  32'h7FFF_FFFF, 32'h1, 1);
    issue(ALU_ADDU, 32'h7FFF_FFFF, 32'h1, 1);
    issue(ALU_SLL,  32'd4,  32'd1, 1);
    issue(ALU_SRA,  32'd31, 32'h8000_0000, 1);
    issue(ALU_SLTU, 32'd1,  32'hFFFF_FFFF, 1);

    alu_ops = '{ALU_AND, ALU_OR, ALU_XOR, ALU_NOR, ALU_SUB, ALU_SUBU,
                ALU_SLT, ALU_SRL, ALU_LUI, ALU_PASSA, ALU_PASSB, ALU_SUB};
    alu_a   = '{32'hF0F0_1234, 32'h0F00_0001, 32'hFFFF_0000, 32'h1234_5678, 32'h8000_0000, 32'h0,
                32'hFFFF_FFFF, 32'd36, 32'hDEAD_BEEF, 32'hCAFE_F00D, 32'h1, 32'h7FFF_FFFF};
    alu_b   = '{32'h0FF0_FFFF, 32'h00F0_0010, 32'h0F0F_0F0F, 32'h0000_FFFF, 32'h1, 32'h1,
                32'h1, 32'h8000_0000, 32'h0000_ABCD, 32'h5, 32'h1357_9BDF, 32'hFFFF_FFFF};
    for (int i = 0; i < 12; i++) issue(alu_ops[i], alu_a[i], alu_b[i], 1);
    unk = 5'd25;
    issue(aluop_t'(unk), 32'h1234_5678, 32'h9ABC_DEF0, 1);
    wait_drain();

    issue(MDU_MULT, 32'hFFFF_FFFD, 32'd5, 1);
    for (int i = 0; i < 3; i++) begin
      #1; check_val("mul_in_ready", in_ready, 0);
      @(negedge clk);
    end
    wait_drain();

    issue(MDU_DIV,  32'hFFFF_FFF9, 32'd2, 1);
    issue(MDU_DIVU, 32'h0001_2345, 32'd0, 1);
    issue(MDU_DIV,  32'h8000_0000, 32'hFFFF_FFFF, 1);
    issue(MDU_DIV,  32'hFFFF_FFFB, 32'd0, 1);
    issue(MDU_DIVU, 32'hFFFF_FFF0, 32'd7, 1);
    wait_drain();

    // Back-pressure on an MDU result.
    out_ready = 1'b0;
    issue(MDU_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1);
    begin
      int n = 0;
      #1;
      while (!out_valid && n < 20) begin
        @(negedge clk); #1; n++;
      end
      check_val("stall_valid", out_valid, 1);
    end
    repeat (5) begin
      @(negedge clk); #1;
      check_val("stall_hold_ready", in_ready, 0);
    end
    @(negedge clk);
    out_ready = 1'b1;
    wait_drain();

    // Flush a division mid-flight; no result may ever appear.
    issue(MDU_DIV, 32'd1000, 32'd7, 0);
    repeat (9) @(negedge clk);
    flush = 1'b1;
    #1; check_val("flush_in_ready", in_ready, 0);
    @(negedge clk);
    flush = 1'b0;
    #1; check_val("post_flush_in_ready", in_ready, 1);
    repeat (40) @(negedge clk);
    issue(ALU_AND, 32'hFF00_FF00, 32'h0FF0_0FF0, 1);
    wait_drain();

    // Reset mid-division abandons the op.
    issue(MDU_DIVU, 32'd1000, 32'd3, 0);
    repeat (5) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    #1; check_val("post_reset_in_ready", in_ready, 1);
    @(negedge clk);
    repeat (40) @(negedge clk);

    for (int i = 0; i < 30; i++) begin
      logic [4:0]  fsel;
      logic [31:0] ra, rb;
      fsel = 5'($urandom_range(0, 19));
      ra = $urandom();
      rb = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 9)) : $urandom();
      issue(aluop_t'(fsel), ra, rb, 1);
    end
    wait_drain();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
